// File: rtl/core_run_sequencer.sv
// Boot/run sequencer for the RV32I core: streams a program into instruction memory,
// holds the core in reset while loading, then runs, halts and single-steps it.
//
// state | meaning
// IDLE  | core held in reset, waiting for a load or run request
// LOAD  | core held in reset, accepting program words into imem
// RUN   | core enabled every cycle until halt, EBREAK or cycle limit
// HALT  | core out of reset but stalled; may step, resume or reload
module core_run_sequencer #(
   parameter int          IMEM_DEPTH = 256,
   parameter int          ADDR_W     = 8,
   parameter int unsigned MAX_CYCLES = 0,
   parameter int          AUTO_RUN   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [31:0]       load_data,
   input  logic              load_last,
   output logic              load_ready,
   input  logic              run_req,
   input  logic              halt_req,
   input  logic              step_req,
   input  logic [31:0]       fetched_instr,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              core_en,
   output logic [1:0]        state,
   output logic              done,
   output logic              error,
   output logic [31:0]       cycle_count
);

   localparam logic [31:0]   EBREAK = 32'h0010_0073;
   localparam logic [ADDR_W:0] DEPTH = IMEM_DEPTH[ADDR_W:0];

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [ADDR_W:0] addr_q, addr_d;
   logic [31:0]     count_q, count_d;
   logic            done_q, done_d;
   logic            error_q, error_d;
   logic            step_q, step_d;
   logic            xfer, ebreak, limit_hit;

   // Gating with rst keeps a mid-load reset from writing imem in the reset cycle.
   assign load_ready  = !rst && (state_q == S_LOAD) && (addr_q < DEPTH);
   assign xfer        = load_valid && load_ready;
   assign imem_we     = xfer;
   assign imem_addr   = addr_q[ADDR_W-1:0];
   assign imem_wdata  = xfer ? load_data : 32'd0;
   assign core_rst    = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign core_en     = (state_q == S_RUN) || step_q;
   assign ebreak      = (fetched_instr == EBREAK);
   assign limit_hit   = (MAX_CYCLES != 0) && (count_q + 32'd1 == MAX_CYCLES);
   assign state       = state_q;
   assign done        = done_q;
   assign error       = error_q;
   assign cycle_count = count_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      done_d  = done_q;
      error_d = error_q;
      step_d  = 1'b0;
      count_d = (core_en && count_q != 32'hFFFF_FFFF) ? count_q + 32'd1 : count_q;
      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               state_d = S_LOAD;
               addr_d  = '0;
               done_d  = 1'b0;
               error_d = 1'b0;
               count_d = '0;
            end else if (run_req) begin
               state_d = S_RUN;
               done_d  = 1'b0;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               addr_d = addr_q + 1'b1;
               if (load_last) begin
                  state_d = (AUTO_RUN != 0) ? S_RUN : S_HALT;
               end else if (addr_q == DEPTH - 1'b1) begin
                  error_d = 1'b1;
                  state_d = S_IDLE;
               end
            end
            if (halt_req) begin
               state_d = S_IDLE;
               error_d = 1'b0;
            end
         end
         S_RUN: begin
            if (halt_req || ebreak || limit_hit) state_d = S_HALT;
            if (ebreak || limit_hit) done_d = 1'b1;
         end
         S_HALT: begin
            if (step_q && ebreak) done_d = 1'b1;
            if (load_start) begin
               state_d = S_LOAD;
               addr_d  = '0;
               done_d  = 1'b0;
               error_d = 1'b0;
               count_d = '0;
            end else if (run_req) begin
               state_d = S_RUN;
               done_d  = 1'b0;
            end else if (step_req && !step_q) begin
               step_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         done_q  <= done_d;
         error_q <= error_d;
         step_q  <= step_d;
      end
   end

endmodule

// File: tb/tb_core_run_sequencer.sv
// Bench for core_run_sequencer: default, cycle-limited and 4-word-imem instances share
// stimulus; a small behavioural model supplies the expected writes, counts and states.
module tb_core_run_sequencer;

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
   logic        run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0;
   logic [31:0] load_data = '0, fetched_instr = '0;

   logic        a_ready, a_we, a_crst, a_en, a_done, a_err;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata, a_cnt;
   logic [1:0]  a_state;
   logic        l_ready, l_we, l_crst, l_en, l_done, l_err;
   logic [7:0]  l_addr;
   logic [31:0] l_wdata, l_cnt;
   logic [1:0]  l_state;
   logic        s_ready, s_we, s_crst, s_en, s_done, s_err;
   logic [1:0]  s_addr;
   logic [31:0] s_wdata, s_cnt;
   logic [1:0]  s_state;

   core_run_sequencer dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
      .load_data(load_data), .load_last(load_last), .load_ready(a_ready),
      .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
      .fetched_instr(fetched_instr), .imem_we(a_we), .imem_addr(a_addr),
      .imem_wdata(a_wdata), .core_rst(a_crst), .core_en(a_en), .state(a_state),
      .done(a_done), .error(a_err), .cycle_count(a_cnt));

   core_run_sequencer #(.MAX_CYCLES(10)) dut_lim (
      .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
      .load_data(load_data), .load_last(load_last), .load_ready(l_ready),
      .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
      .fetched_instr(fetched_instr), .imem_we(l_we), .imem_addr(l_addr),
      .imem_wdata(l_wdata), .core_rst(l_crst), .core_en(l_en), .state(l_state),
      .done(l_done), .error(l_err), .cycle_count(l_cnt));

   core_run_sequencer #(.IMEM_DEPTH(4), .ADDR_W(2)) dut_small (
      .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
      .load_data(load_data), .load_last(load_last), .load_ready(s_ready),
      .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
      .fetched_instr(fetched_instr), .imem_we(s_we), .imem_addr(s_addr),
      .imem_wdata(s_wdata), .core_rst(s_crst), .core_en(s_en), .state(s_state),
      .done(s_done), .error(s_err), .cycle_count(s_cnt));

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          sel = 0;
   int          exp_count = 0;
   logic [31:0] prog[$];

   // View of whichever instance the current test targets.
   logic        m_ready, m_we, m_crst, m_en, m_done, m_err;
   logic [31:0] m_addr, m_wdata, m_cnt;
   logic [1:0]  m_state;
   always_comb begin
      m_ready = a_ready; m_we = a_we; m_crst = a_crst; m_en = a_en; m_done = a_done;
      m_err = a_err; m_addr = 32'(a_addr); m_wdata = a_wdata; m_cnt = a_cnt; m_state = a_state;
      case (sel)
         1: begin
            m_ready = l_ready; m_we = l_we; m_crst = l_crst; m_en = l_en; m_done = l_done;
            m_err = l_err; m_addr = 32'(l_addr); m_wdata = l_wdata; m_cnt = l_cnt; m_state = l_state;
         end
         2: begin
            m_ready = s_ready; m_we = s_we; m_crst = s_crst; m_en = s_en; m_done = s_done;
            m_err = s_err; m_addr = 32'(s_addr); m_wdata = s_wdata; m_cnt = s_cnt; m_state = s_state;
         end
         default: ;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [31:0] v;
      v = $urandom;
      if (v == EBREAK) v = 32'h0000_0013;
      return v;
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Streams prog[] with random valid gaps; each accepted word must hit imem at its index.
   task automatic do_load(input bit with_last);
      int i = 0;
      int guard = 0;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      #1;
      total++; if (m_state !== 2'd1) begin bad++; $display("FAIL load_entry_state got=%0d want=1", m_state); end
      total++; if (m_done !== 1'b0 || m_err !== 1'b0) begin bad++; $display("FAIL load_entry_flags done=%b err=%b want 0 0", m_done, m_err); end
      total++; if (m_cnt !== 32'd0) begin bad++; $display("FAIL load_entry_count got=%0d want=0", m_cnt); end
      while (i < prog.size() && guard < 200) begin
         guard++;
         load_valid = ($urandom_range(0, 3) != 0);
         load_data  = load_valid ? prog[i] : $urandom;
         load_last  = with_last && (i == prog.size() - 1);
         #1;
         total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%b want=1 idx=%0d", m_ready, i); end
         total++; if (m_we !== load_valid) begin bad++; $display("FAIL load_we got=%b want=%b idx=%0d", m_we, load_valid, i); end
         total++; if (m_crst !== 1'b1) begin bad++; $display("FAIL load_core_rst got=%b want=1", m_crst); end
         if (load_valid) begin
            total++; if (m_addr !== 32'(i)) begin bad++; $display("FAIL load_addr got=%0d want=%0d", m_addr, i); end
            total++; if (m_wdata !== prog[i]) begin bad++; $display("FAIL load_wdata got=%h want=%h", m_wdata, prog[i]); end
            i++;
         end
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      if (guard >= 200) begin total++; bad++; $display("FAIL load_timeout sent=%0d want=%0d", i, prog.size()); end
   endtask

   // Runs from RUN cycle 1; the stop event lands in cycle stop_at, which is still counted.
   task automatic run_until(input int stop_at, input bit by_ebreak);
      for (int c = 1; c <= stop_at; c++) begin
         fetched_instr = (by_ebreak && c == stop_at) ? EBREAK : rnd_instr();
         halt_req      = !by_ebreak && (c == stop_at);
         #1;
         total++; if (m_en !== 1'b1) begin bad++; $display("FAIL run_en got=%b want=1 cycle=%0d", m_en, c); end
         tick();
      end
      halt_req = 1'b0;
      fetched_instr = rnd_instr();
      exp_count += stop_at;
      #1;
      total++; if (m_state !== 2'd3) begin bad++; $display("FAIL run_stop_state got=%0d want=3", m_state); end
      total++; if (m_en !== 1'b0) begin bad++; $display("FAIL run_stop_en got=%b want=0", m_en); end
      total++; if (m_done !== by_ebreak) begin bad++; $display("FAIL run_stop_done got=%b want=%b", m_done, by_ebreak); end
      total++; if (m_cnt !== 32'(exp_count)) begin bad++; $display("FAIL run_stop_count got=%0d want=%0d", m_cnt, exp_count); end
   endtask

   task automatic test_reset();
      sel = 0;
      rst = 1'b1;
      load_valid = 1'b1;
      load_data = 32'hDEAD_BEEF;
      tick();
      tick();
      #1;
      total++; if (a_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", a_state); end
      total++; if (a_crst !== 1'b1 || a_en !== 1'b0) begin bad++; $display("FAIL reset_core got rst=%b en=%b want 1 0", a_crst, a_en); end
      total++; if (a_ready !== 1'b0 || a_we !== 1'b0) begin bad++; $display("FAIL reset_load got ready=%b we=%b want 0 0", a_ready, a_we); end
      total++; if (a_addr !== 8'd0 || a_wdata !== 32'd0) begin bad++; $display("FAIL reset_imem got addr=%0d wdata=%h want 0 0", a_addr, a_wdata); end
      total++; if (a_done !== 1'b0 || a_err !== 1'b0 || a_cnt !== 32'd0) begin bad++; $display("FAIL reset_flags got done=%b err=%b cnt=%0d", a_done, a_err, a_cnt); end
      rst = 1'b0;
      load_valid = 1'b0;
   endtask

   task automatic test_load_and_ebreak();
      sel = 0;
      apply_reset();
      prog = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0010_0073};
      do_load(1'b1);
      #1;
      total++; if (a_state !== 2'd2) begin bad++; $display("FAIL load_to_run got=%0d want=2", a_state); end
      total++; if (a_crst !== 1'b0) begin bad++; $display("FAIL core_rst_fall got=%b want=0", a_crst); end
      exp_count = 0;
      run_until(3, 1'b1);
   endtask

   task automatic test_step();
      sel = 0;
      for (int s = 0; s < 3; s++) begin
         fetched_instr = rnd_instr();
         step_req = 1'b1;
         #1;
         total++; if (a_en !== 1'b0) begin bad++; $display("FAIL step_pre_en got=%b want=0", a_en); end
         tick();
         step_req = 1'b0;
         #1;
         total++; if (a_en !== 1'b1) begin bad++; $display("FAIL step_pulse got=%b want=1", a_en); end
         tick();
         #1;
         total++; if (a_en !== 1'b0) begin bad++; $display("FAIL step_single got=%b want=0", a_en); end
         tick();
         tick();
      end
      exp_count += 3;
      total++; if (a_cnt !== 32'(exp_count)) begin bad++; $display("FAIL step_count got=%0d want=%0d", a_cnt, exp_count); end
      total++; if (a_state !== 2'd3) begin bad++; $display("FAIL step_state got=%0d want=3", a_state); end
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      #1;
      total++; if (a_state !== 2'd2 || a_done !== 1'b0) begin bad++; $display("FAIL resume got state=%0d done=%b want 2 0", a_state, a_done); end
      run_until($urandom_range(1, 6), 1'b0);
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      fetched_instr = EBREAK;
      tick();
      fetched_instr = rnd_instr();
      exp_count += 1;
      #1;
      total++; if (a_done !== 1'b1 || a_state !== 2'd3) begin bad++; $display("FAIL step_ebreak got done=%b state=%0d want 1 3", a_done, a_state); end
      total++; if (a_cnt !== 32'(exp_count)) begin bad++; $display("FAIL step_ebreak_count got=%0d want=%0d", a_cnt, exp_count); end
   endtask

   task automatic test_cycle_limit();
      int en_cycles = 0;
      sel = 1;
      apply_reset();
      prog = '{$urandom, $urandom};
      do_load(1'b1);
      for (int c = 0; c < 15; c++) begin
         fetched_instr = rnd_instr();
         #1;
         if (l_en) en_cycles++;
         tick();
      end
      total++; if (en_cycles != 10) begin bad++; $display("FAIL limit_en_cycles got=%0d want=10", en_cycles); end
      total++; if (l_state !== 2'd3 || l_done !== 1'b1) begin bad++; $display("FAIL limit_stop got state=%0d done=%b want 3 1", l_state, l_done); end
      total++; if (l_cnt !== 32'd10) begin bad++; $display("FAIL limit_count got=%0d want=10", l_cnt); end
   endtask

   task automatic test_overflow();
      sel = 2;
      apply_reset();
      prog = '{$urandom, $urandom, $urandom, $urandom};
      do_load(1'b0);
      #1;
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%b want=0", s_ready); end
      total++; if (s_err !== 1'b1) begin bad++; $display("FAIL ovf_error got=%b want=1", s_err); end
      total++; if (s_state !== 2'd0) begin bad++; $display("FAIL ovf_state got=%0d want=0", s_state); end
   endtask

   task automatic test_halt_in_load();
      sel = 0;
      apply_reset();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data = $urandom;
      tick();
      load_valid = 1'b0;
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      #1;
      total++; if (a_state !== 2'd0 || a_err !== 1'b0 || a_crst !== 1'b1) begin bad++; $display("FAIL load_halt got state=%0d err=%b crst=%b want 0 0 1", a_state, a_err, a_crst); end
   endtask

   task automatic test_reset_mid_load();
      sel = 0;
      apply_reset();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load_valid = 1'b1;
         load_data = $urandom;
         #1;
         total++; if (a_we !== 1'b1 || a_addr !== 8'(i)) begin bad++; $display("FAIL midrst_pre got we=%b addr=%0d want 1 %0d", a_we, a_addr, i); end
         tick();
      end
      rst = 1'b1;
      #1;
      total++; if (a_we !== 1'b0) begin bad++; $display("FAIL midrst_we_in_rst got=%b want=0", a_we); end
      tick();
      #1;
      total++; if (a_state !== 2'd0 || a_crst !== 1'b1 || a_we !== 1'b0) begin bad++; $display("FAIL midrst_state got state=%0d crst=%b we=%b", a_state, a_crst, a_we); end
      tick();
      rst = 1'b0;
      #1;
      total++; if (a_we !== 1'b0 || a_ready !== 1'b0) begin bad++; $display("FAIL midrst_after got we=%b ready=%b want 0 0", a_we, a_ready); end
      tick();
      load_valid = 1'b0;
      #1;
      total++; if (a_state !== 2'd0) begin bad++; $display("FAIL midrst_idle got=%0d want=0", a_state); end
   endtask

   // Back-to-back random programs; after the first, each load starts straight from HALT.
   task automatic test_random_programs();
      sel = 0;
      apply_reset();
      for (int it = 0; it < 12; it++) begin
         int n;
         n = $urandom_range(1, 8);
         prog.delete();
         for (int k = 0; k < n; k++) prog.push_back(rnd_instr());
         do_load(1'b1);
         #1;
         total++; if (a_state !== 2'd2) begin bad++; $display("FAIL rand_run_entry got=%0d want=2 iter=%0d", a_state, it); end
         exp_count = 0;
         run_until($urandom_range(1, 10), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      fetched_instr = rnd_instr();
      test_reset();
      test_load_and_ebreak();
      test_step();
      test_cycle_limit();
      test_overflow();
      test_halt_in_load();
      test_reset_mid_load();
      test_random_programs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
